// File: rtl/ebi_mailbox.sv
// EBI chip-select register/FIFO mailbox: down FIFO (CPU->fabric), up FIFO (fabric->CPU), active-low IRQ.
// Define EBI_MAILBOX_ERR_EN to build the sticky overflow/underflow bits and their interrupt enable.
module ebi_mailbox #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter logic [15:0] ID_VALUE   = 16'h4D42
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        wr_stb_i,
   input  logic        rd_stb_i,
   input  logic [2:0]  addr_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   input  logic        fab_push_i,
   input  logic [15:0] fab_wdata_i,
   output logic        fab_full_o,
   input  logic        fab_pop_i,
   output logic [15:0] fab_rdata_o,
   output logic        fab_empty_o,
   output logic        irq_o
);

   localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
   localparam int unsigned LW    = DEPTH_LOG2 + 32'd1;
   localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0]         LVL_ONE  = LW'(32'd1);
   localparam logic [LW-1:0]         LVL_ZERO = LW'(32'd0);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(32'd1);

   logic [15:0]           up_mem_q [DEPTH];
   logic [15:0]           dn_mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] up_wp_q, up_wp_d, up_rp_q, up_rp_d;
   logic [DEPTH_LOG2-1:0] dn_wp_q, dn_wp_d, dn_rp_q, dn_rp_d;
   logic [LW-1:0]         up_lvl_q, up_lvl_d, dn_lvl_q, dn_lvl_d;
   logic [15:0]           rdata_q, rdata_d, dn_head_q, dn_head_d, scratch_q, scratch_d;
   logic [15:0]           rd_val_s, status_s;
   logic [2:0]            en_q, en_d, sticky_s;
   logic                  irq_q, irq_d, full_q, full_d, empty_q, empty_d, en2_wr_s;
   logic                  up_empty_s, up_full_s, dn_empty_s, dn_full_s;
   logic                  up_pop_req_s, dn_push_req_s, up_pop_s, up_push_s, dn_pop_s, dn_push_s;

   assign up_empty_s    = (up_lvl_q == LVL_ZERO);
   assign up_full_s     = (up_lvl_q == LVL_FULL);
   assign dn_empty_s    = (dn_lvl_q == LVL_ZERO);
   assign dn_full_s     = (dn_lvl_q == LVL_FULL);
   assign up_pop_req_s  = rd_stb_i & (addr_i == 3'd0);
   assign dn_push_req_s = wr_stb_i & (addr_i == 3'd0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign up_pop_s      = up_pop_req_s & ~up_empty_s;
   assign up_push_s     = fab_push_i & (~up_full_s | up_pop_s);
   assign dn_pop_s      = fab_pop_i & ~dn_empty_s;
   assign dn_push_s     = dn_push_req_s & (~dn_full_s | dn_pop_s);

`ifdef EBI_MAILBOX_ERR_EN
   logic [2:0] sticky_q, sticky_d, sticky_set_s, sticky_clr_s;

   // Sticky order: {up_unf, dn_ovf, up_ovf}, matching STATUS bits 6..4; set beats clear.
   assign sticky_set_s = {up_pop_req_s & up_empty_s, dn_push_req_s & ~dn_push_s, fab_push_i & ~up_push_s};
   assign sticky_clr_s = (wr_stb_i && (addr_i == 3'd1)) ? wdata_i[6:4] : 3'b000;
   assign sticky_d     = (sticky_q & ~sticky_clr_s) | sticky_set_s;
   assign sticky_s     = sticky_q;
   assign en2_wr_s     = wdata_i[2];

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sticky_q <= 3'b000;
      end else begin
         sticky_q <= sticky_d;
      end
   end
`else
   assign sticky_s = 3'b000;
   assign en2_wr_s = 1'b0;
`endif

   assign status_s = {8'(up_lvl_q), 1'b0, sticky_s, dn_full_s, dn_empty_s, up_full_s, up_empty_s};

   always_comb begin
      up_wp_d  = up_push_s ? up_wp_q + PTR_ONE : up_wp_q;
      up_rp_d  = up_pop_s  ? up_rp_q + PTR_ONE : up_rp_q;
      dn_wp_d  = dn_push_s ? dn_wp_q + PTR_ONE : dn_wp_q;
      dn_rp_d  = dn_pop_s  ? dn_rp_q + PTR_ONE : dn_rp_q;
      case ({up_push_s, up_pop_s})
         2'b10:   up_lvl_d = up_lvl_q + LVL_ONE;
         2'b01:   up_lvl_d = up_lvl_q - LVL_ONE;
         default: up_lvl_d = up_lvl_q;
      endcase
      case ({dn_push_s, dn_pop_s})
         2'b10:   dn_lvl_d = dn_lvl_q + LVL_ONE;
         2'b01:   dn_lvl_d = dn_lvl_q - LVL_ONE;
         default: dn_lvl_d = dn_lvl_q;
      endcase
      // Show-ahead head: when the word being written becomes the head, bypass the memory.
      if (dn_lvl_d != LVL_ZERO) begin
         if (dn_push_s && (dn_wp_q == dn_rp_d)) begin
            dn_head_d = wdata_i;
         end else begin
            dn_head_d = dn_mem_q[dn_rp_d];
         end
      end else begin
         dn_head_d = dn_head_q;
      end
      full_d  = (up_lvl_d == LVL_FULL);
      empty_d = (dn_lvl_d == LVL_ZERO);
   end

   always_comb begin
      case (addr_i)
         3'd0:    rd_val_s = up_empty_s ? 16'h0000 : up_mem_q[up_rp_q];
         3'd1:    rd_val_s = status_s;
         3'd2:    rd_val_s = {13'h0000, en_q};
         3'd3:    rd_val_s = scratch_q;
         3'd4:    rd_val_s = ID_VALUE;
         default: rd_val_s = 16'h0000;
      endcase
      rdata_d   = rd_stb_i ? rd_val_s : rdata_q;
      en_d      = (wr_stb_i && (addr_i == 3'd2)) ? {en2_wr_s, wdata_i[1:0]} : en_q;
      scratch_d = (wr_stb_i && (addr_i == 3'd3)) ? wdata_i : scratch_q;
      irq_d     = ~((en_q[0] & ~up_empty_s) | (en_q[1] & dn_empty_s) | (en_q[2] & (|sticky_s)));
   end

   // FIFO storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (up_push_s) begin
         up_mem_q[up_wp_q] <= fab_wdata_i;
      end
      if (dn_push_s) begin
         dn_mem_q[dn_wp_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         up_wp_q   <= {DEPTH_LOG2{1'b0}};
         up_rp_q   <= {DEPTH_LOG2{1'b0}};
         dn_wp_q   <= {DEPTH_LOG2{1'b0}};
         dn_rp_q   <= {DEPTH_LOG2{1'b0}};
         up_lvl_q  <= LVL_ZERO;
         dn_lvl_q  <= LVL_ZERO;
         dn_head_q <= 16'h0000;
         rdata_q   <= 16'h0000;
         scratch_q <= 16'h0000;
         en_q      <= 3'b000;
         irq_q     <= 1'b1;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         up_wp_q   <= up_wp_d;
         up_rp_q   <= up_rp_d;
         dn_wp_q   <= dn_wp_d;
         dn_rp_q   <= dn_rp_d;
         up_lvl_q  <= up_lvl_d;
         dn_lvl_q  <= dn_lvl_d;
         dn_head_q <= dn_head_d;
         rdata_q   <= rdata_d;
         scratch_q <= scratch_d;
         en_q      <= en_d;
         irq_q     <= irq_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
      end
   end

   assign rdata_o     = rdata_q;
   assign fab_rdata_o = dn_head_q;
   assign fab_full_o  = full_q;
   assign fab_empty_o = empty_q;
   assign irq_o       = irq_q;

endmodule
